// File: rtl/motor_ctrl_pkg.sv
// Shared types and helpers for the vacuum drive motor duty sequencer.
// The step helper saturates against the goal in both directions so duty never wraps or overshoots.
package motor_ctrl_pkg;

    localparam int DUTY_W = 10;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RAMP  = 3'd1,
        BRAKE = 3'd2,
        DWELL = 3'd3,
        ESTOP = 3'd4
    } ctrl_state_e;

    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] goal,
        input logic [DUTY_W:0]   step
    );
        logic [DUTY_W:0] cur_x;
        logic [DUTY_W:0] goal_x;
        logic [DUTY_W:0] calc_x;
        cur_x  = {1'b0, cur};
        goal_x = {1'b0, goal};
        if (cur_x < goal_x) begin
            calc_x = cur_x + step;
            step_toward = (calc_x > goal_x) ? goal : DUTY_W'(calc_x);
        end else begin
            calc_x = cur_x - goal_x;
            step_toward = (calc_x <= step) ? goal : DUTY_W'(cur_x - step);
        end
    endfunction

endpackage

// File: rtl/ramp_tick_gen.sv
// Ramp prescaler: counts 0..TICK_DIV-1 while enabled and pulses tick on the terminal count.
// A clear (or dropping enable) restarts the count from zero so the next tick is a full period away.
module ramp_tick_gen #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick = en && !clr && (cnt_q == CNT_TERM);

    // Next count: restart on clear/disable or wrap at the terminal count.
    always_comb begin
        cnt_d = cnt_q;
        if (clr || !en) begin
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_TERM) begin
            cnt_d = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= CNT_ZERO;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/motor_ramp_ctrl.sv
// Soft start/stop sequencer for the motor PWM duty, with braked direction reversal and e-stop.
// Outputs are registered; only cmd_ready is combinational so a command is taken in the cycle it is offered.
module motor_ramp_ctrl
    import motor_ctrl_pkg::*;
#(
    parameter int STEP        = 8,
    parameter int TICK_DIV    = 1000,
    parameter int DEAD_CYCLES = 5000,
    parameter int MAX_DUTY    = 1023
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DUTY_W-1:0] cmd_duty,
    input  logic              cmd_dir,
    input  logic              estop,
    output logic [DUTY_W-1:0] duty,
    output logic              dir,
    output logic              busy,
    output logic              at_target
);

    localparam int DWELL_W = $clog2(DEAD_CYCLES + 1);
    localparam logic [DUTY_W:0]    STEP_X     = (DUTY_W + 1)'(STEP);
    localparam logic [DUTY_W-1:0]  MAX_V      = DUTY_W'(MAX_DUTY);
    localparam logic [DUTY_W-1:0]  ZERO_DUTY  = {DUTY_W{1'b0}};
    localparam logic [DWELL_W-1:0] DWELL_LOAD = DWELL_W'(DEAD_CYCLES);
    localparam logic [DWELL_W-1:0] ZERO_DWELL = {DWELL_W{1'b0}};
    localparam logic [DWELL_W-1:0] ONE_DWELL  = DWELL_W'(1);

    ctrl_state_e       state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic              dir_q, dir_d;
    logic              tgt_dir_q, tgt_dir_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic              busy_q, busy_d;
    logic              at_target_q, at_target_d;

    logic              accept_s;
    logic              tick_s;
    logic              tick_en_s;
    logic [DUTY_W-1:0] cmd_tgt_s;

    assign cmd_ready = ((state_q == IDLE) || (state_q == RAMP)) && !estop;
    assign accept_s  = cmd_valid && cmd_ready;
    assign cmd_tgt_s = (cmd_duty > MAX_V) ? MAX_V : cmd_duty;
    assign tick_en_s = (state_q == RAMP) || (state_q == BRAKE);

    ramp_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (tick_en_s),
        .clr  (accept_s || estop),
        .tick (tick_s)
    );

    // Next-state, duty stepping and registered-output prediction.
    always_comb begin
        state_d   = state_q;
        duty_d    = duty_q;
        target_d  = target_q;
        dir_d     = dir_q;
        tgt_dir_d = tgt_dir_q;
        dwell_d   = dwell_q;
        if (estop) begin
            state_d  = ESTOP;
            duty_d   = ZERO_DUTY;
            target_d = ZERO_DUTY;
            dwell_d  = ZERO_DWELL;
        end else if (accept_s) begin
            target_d  = cmd_tgt_s;
            tgt_dir_d = cmd_dir;
            if (cmd_dir == dir_q) begin
                state_d = RAMP;
            end else if (duty_q != ZERO_DUTY) begin
                state_d = BRAKE;
            end else begin
                state_d = DWELL;
                dwell_d = DWELL_LOAD;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                RAMP: begin
                    if (duty_q == target_q) begin
                        state_d = IDLE;
                    end else if (tick_s) begin
                        duty_d = step_toward(duty_q, target_q, STEP_X);
                    end else begin
                        duty_d = duty_q;
                    end
                end
                BRAKE: begin
                    if (duty_q == ZERO_DUTY) begin
                        state_d = DWELL;
                        dwell_d = DWELL_LOAD;
                    end else if (tick_s) begin
                        duty_d = step_toward(duty_q, ZERO_DUTY, STEP_X);
                    end else begin
                        duty_d = duty_q;
                    end
                end
                DWELL: begin
                    // The direction only ever changes here, after the full zero-duty dwell.
                    if (dwell_q <= ONE_DWELL) begin
                        dwell_d = ZERO_DWELL;
                        dir_d   = tgt_dir_q;
                        state_d = (target_q != ZERO_DUTY) ? RAMP : IDLE;
                    end else begin
                        dwell_d = dwell_q - ONE_DWELL;
                    end
                end
                ESTOP: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
        busy_d      = (state_d != IDLE);
        at_target_d = (state_d == IDLE) && (duty_d == target_d);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            duty_q      <= ZERO_DUTY;
            target_q    <= ZERO_DUTY;
            dir_q       <= DIR_FWD;
            tgt_dir_q   <= DIR_FWD;
            dwell_q     <= ZERO_DWELL;
            busy_q      <= 1'b0;
            at_target_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            target_q    <= target_d;
            dir_q       <= dir_d;
            tgt_dir_q   <= tgt_dir_d;
            dwell_q     <= dwell_d;
            busy_q      <= busy_d;
            at_target_q <= at_target_d;
        end
    end

    assign duty      = duty_q;
    assign dir       = dir_q;
    assign busy      = busy_q;
    assign at_target = at_target_q;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: a timed event model predicts every duty/dir change;
// a monitor pops the scoreboard whenever the DUT's duty or dir moves.
module tb_motor_ramp_ctrl;
    import motor_ctrl_pkg::*;

    localparam int TD = 4;
    localparam int ST = 16;
    localparam int DC = 10;
    localparam int MX = 1000;

    logic              clk = 1'b0;
    logic              rst;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DUTY_W-1:0] cmd_duty;
    logic              cmd_dir;
    logic              estop;
    logic [DUTY_W-1:0] duty;
    logic              dir;
    logic              busy;
    logic              at_target;

    motor_ramp_ctrl #(
        .STEP(ST), .TICK_DIV(TD), .DEAD_CYCLES(DC), .MAX_DUTY(MX)
    ) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_duty(cmd_duty), .cmd_dir(cmd_dir), .estop(estop),
        .duty(duty), .dir(dir), .busy(busy), .at_target(at_target)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int t;
        int d;
        bit r;
    } ev_t;

    ev_t evq[$];
    int  tests = 0;
    int  fails = 0;
    int  exp_duty = 0;
    bit  exp_dir = 1'b0;
    int  prev_duty = 0;
    bit  prev_dir = 1'b0;
    bit  mon_en = 1'b0;

    function automatic void chk(string nm, int act, int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void push_ev(int t, int d, bit r);
        ev_t e;
        e.t = t; e.d = d; e.r = r;
        evq.push_back(e);
    endfunction

    function automatic void prune(int from_t);
        ev_t keep[$];
        foreach (evq[i]) if (evq[i].t < from_t) keep.push_back(evq[i]);
        evq = keep;
    endfunction

    function automatic int stepv(int cur, int goal);
        if (cur < goal) return (cur + ST > goal) ? goal : cur + ST;
        return (cur - goal <= ST) ? goal : cur - ST;
    endfunction

    // Model of one accepted command: predicted change events, IDLE time, and when cmd_ready returns.
    function automatic void sched(int T, int cur, bit cd, int cmdd, bit tdir,
                                  output int idle_t, output int rl);
        int t;
        int tgt;
        t = T;
        rl = T;
        tgt = (cmdd > MX) ? MX : cmdd;
        if (tdir != cd) begin
            if (cur != 0) begin
                while (cur != 0) begin
                    t += TD;
                    cur = stepv(cur, 0);
                    push_ev(t, cur, cd);
                end
                t += 1;
            end
            t += DC;
            push_ev(t, 0, tdir);
            rl = t;
            if (tgt == 0) begin
                idle_t = t;
                return;
            end
        end
        while (cur != tgt) begin
            t += TD;
            cur = stepv(cur, tgt);
            push_ev(t, cur, tdir);
        end
        idle_t = t + 1;
    endfunction

    // Monitor: every change of {dir,duty} must match the next scheduled event.
    always @(negedge clk) begin
        if (mon_en) begin
            while (evq.size() > 0 && evq[0].t < cyc) begin
                tests++;
                fails++;
                $display("FAIL missed_event: got no change, expected duty %0d dir %0d at cycle %0d",
                         evq[0].d, evq[0].r, evq[0].t);
                exp_duty = evq[0].d;
                exp_dir  = evq[0].r;
                void'(evq.pop_front());
            end
            if (int'(duty) != prev_duty || dir != prev_dir) begin
                if (evq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_change: got duty %0d dir %0d, expected no change (cycle %0d)",
                             duty, dir, cyc);
                end else begin
                    ev_t e;
                    e = evq.pop_front();
                    chk("event_time", cyc, e.t);
                    chk("event_duty", int'(duty), e.d);
                    chk("event_dir", int'(dir), int'(e.r));
                    exp_duty = e.d;
                    exp_dir  = e.r;
                end
            end
            prev_duty = int'(duty);
            prev_dir  = dir;
        end
    end

    task automatic tick_n();
        @(negedge clk);
        #1;
    endtask

    task automatic issue(int d, bit dr, output int T, output int it, output int rl);
        chk("ready_before_cmd", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_duty  = DUTY_W'(d);
        cmd_dir   = dr;
        tick_n();
        T = cyc;
        cmd_valid = 1'b0;
        prune(T);
        sched(T, exp_duty, exp_dir, d, dr, it, rl);
    endtask

    task automatic watch(int it, int rl, int stop_at);
        while (cyc <= it && cyc != stop_at) begin
            chk("cmd_ready", int'(cmd_ready), int'(cyc >= rl));
            chk("busy", int'(busy), int'(cyc < it));
            chk("at_target", int'(at_target), int'(cyc >= it));
            tick_n();
        end
    endtask

    task automatic idle_checks(string nm);
        chk({nm, "_busy"}, int'(busy), 0);
        chk({nm, "_at_target"}, int'(at_target), 1);
        chk({nm, "_ready"}, int'(cmd_ready), 1);
        chk({nm, "_duty"}, int'(duty), 0);
    endtask

    // mode 0: plain, 1: retarget after r cycles, 2: estop after r cycles, 3: reset after r cycles
    task automatic run_cmd(int d, bit dr, int mode, int r, int d2, bit dr2);
        int T, it, rl, Te, k;
        issue(d, dr, T, it, rl);
        if (mode == 0 || (mode == 1 && rl != T)) begin
            watch(it, rl, -1);
        end else begin
            watch(it, rl, T + r);
            if (cyc == T + r) begin
                if (mode == 1) begin
                    issue(d2, dr2, T, it, rl);
                    watch(it, rl, -1);
                end else if (mode == 2) begin
                    estop = 1'b1;
                    cmd_valid = 1'b1;
                    cmd_duty = DUTY_W'($urandom_range(0, 1023));
                    cmd_dir = 1'($urandom_range(0, 1));
                    Te = cyc + 1;
                    prune(Te);
                    if (exp_duty != 0) push_ev(Te, 0, exp_dir);
                    tick_n();
                    k = $urandom_range(1, 5);
                    for (int i = 0; i < k; i++) begin
                        chk("estop_ready", int'(cmd_ready), 0);
                        chk("estop_busy", int'(busy), 1);
                        chk("estop_duty", int'(duty), 0);
                        tick_n();
                    end
                    estop = 1'b0;
                    cmd_valid = 1'b0;
                    tick_n();
                    idle_checks("estop_exit");
                end else begin
                    rst = 1'b1;
                    Te = cyc + 1;
                    prune(Te);
                    if (exp_duty != 0 || exp_dir != 1'b0) push_ev(Te, 0, 1'b0);
                    tick_n();
                    rst = 1'b0;
                    idle_checks("midrst");
                    chk("midrst_dir", int'(dir), 0);
                    tick_n();
                end
            end
        end
    endtask

    initial begin
        int m;
        int md;
        rst = 1'b1;
        cmd_valid = 1'b0;
        cmd_duty = '0;
        cmd_dir = 1'b0;
        estop = 1'b0;
        repeat (3) tick_n();
        rst = 1'b0;
        mon_en = 1'b1;
        tick_n();
        idle_checks("reset");
        chk("reset_dir", int'(dir), 0);

        run_cmd(64, 1'b0, 0, 0, 0, 1'b0);   // ramp up 16/32/48/64
        run_cmd(64, 1'b0, 0, 0, 0, 1'b0);   // same duty, same dir
        run_cmd(70, 1'b0, 0, 0, 0, 1'b0);   // clamp to 70
        run_cmd(0, 1'b0, 0, 0, 0, 1'b0);    // ramp down 54..0
        run_cmd(32, 1'b0, 0, 0, 0, 1'b0);
        run_cmd(32, 1'b1, 0, 0, 0, 1'b0);   // reversal through BRAKE/DWELL
        run_cmd(96, 1'b1, 2, 5, 0, 1'b0);   // estop at duty 48
        chk("estop_dir_held", int'(dir), 1);
        run_cmd(1023, 1'b0, 0, 0, 0, 1'b0); // clip to 1000 after reversal
        chk("clip_duty", int'(duty), 1000);
        run_cmd(0, 1'b0, 0, 0, 0, 1'b0);
        run_cmd(1023, 1'b0, 1, 200, 500, 1'b0); // retarget down mid-ramp
        chk("retarget_duty", int'(duty), 500);
        run_cmd(600, 1'b1, 3, 30, 0, 1'b0); // reset mid-operation

        for (int n = 0; n < 20; n++) begin
            m = $urandom_range(0, 9);
            md = (m < 6) ? 0 : (m < 8) ? 1 : (m == 8) ? 2 : 3;
            run_cmd($urandom_range(0, 1023), 1'($urandom_range(0, 1)), md,
                    $urandom_range(1, 60), $urandom_range(0, 1023), 1'($urandom_range(0, 1)));
        end

        tick_n();
        chk("queue_empty", evq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/motor_ramp_ctrl.md
Name: motor_ramp_ctrl

Overview:
- Sequences the duty-cycle input (`number`, 10-bit) of one `pwm` instance driving a vacuum drive motor.
- Accepts target speed/direction commands over a valid/ready handshake.
- Slews the applied duty toward the target in fixed steps at a fixed tick rate (soft start/stop).
- Forces ramp-to-zero plus a dead-time dwell before any direction reversal, and provides an emergency-stop override.

Parameters:
- DUTY_W, 10, width of duty values; matches `pwm.number`.
- STEP, 8, duty increment/decrement applied per ramp tick.
- TICK_DIV, 1000, clk cycles per ramp tick (≥2).
- DEAD_CYCLES, 5000, clk cycles of zero duty held before a direction flip (≥1).
- MAX_DUTY, 1023, ceiling applied to commanded duty.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, reset. One clock; reset is synchronous and active-high.
- cmd_valid, in, 1, command present.
- cmd_ready, out, 1, command can be accepted this cycle.
- cmd_duty, in, DUTY_W, target duty.
- cmd_dir, in, 1, target direction (0 = forward).
- estop, in, 1, emergency stop, level-sensitive.
- duty, out, DUTY_W, applied duty; connects to `pwm.number`.
- dir, out, 1, applied direction to the H-bridge.
- busy, out, 1, high in every state except IDLE.
- at_target, out, 1, high when state is IDLE and duty == target.

Behaviour:
- Reset values:
  - duty=0, dir=0, target=0, tgt_dir=0.
  - state=IDLE, tick counter=0, dwell counter=0.
  - cmd_ready=1, busy=0, at_target=1.
- States: IDLE, RAMP, BRAKE, DWELL, ESTOP. All outputs are registered except cmd_ready.
- cmd_ready: combinational, = (state==IDLE or RAMP) && !estop.
- Accept: when cmd_valid && cmd_ready.
  - Latch target = min(cmd_duty, MAX_DUTY) and tgt_dir = cmd_dir.
  - Clear the tick counter.
  - A retarget accepted in RAMP takes effect immediately; the ramp continues from the current duty.
- Next state on accept:
  - cmd_dir==dir → RAMP.
  - cmd_dir!=dir and duty!=0 → BRAKE.
  - cmd_dir!=dir and duty==0 → DWELL.
- Tick: the counter counts 0..TICK_DIV-1 in RAMP and BRAKE. A step occurs on the cycle the counter equals TICK_DIV-1. The first step therefore lands TICK_DIV cycles after accept.
- Step arithmetic:
  - Computed at DUTY_W+1 bits.
  - Up step: duty ← min(duty+STEP, goal).
  - Down step: duty ← (duty−goal ≤ STEP) ? goal : duty−STEP.
  - Never wraps, never overshoots.
  - Goal is target in RAMP and 0 in BRAKE.
- RAMP → IDLE on the cycle after duty==target is first observed. Duty is unchanged there; at_target rises with the IDLE entry.
- BRAKE → DWELL when duty==0. The dwell counter loads DEAD_CYCLES.
- DWELL: duty held at 0, counter decrements each cycle. On reaching 0:
  - dir ← tgt_dir.
  - Go to RAMP if target!=0, else IDLE.
  - dir changes only in this transition.
- ESTOP:
  - estop high in any state → next cycle duty=0, target=0, state=ESTOP. Counters are cleared and dir is held.
  - estop has priority over a simultaneous command; none is accepted because cmd_ready=0.
  - estop low while in ESTOP → IDLE next cycle (duty=0, at_target=1).
- rst mid-operation: returns all state to reset values on the next edge regardless of state. rst has priority over estop.
- Command with duty==current and dir==current: enters RAMP and returns to IDLE next cycle; no duty change.

Decomposition:
- Package motor_ctrl_pkg holds:
  - ctrl_state_e enum (IDLE, RAMP, BRAKE, DWELL, ESTOP).
  - DUTY_W localparam.
  - DIR_FWD/DIR_REV constants.
- One sub-module, ramp_tick_gen: TICK_DIV prescaler with enable and sync clear, producing a 1-cycle tick pulse.
- Step/saturate logic and the FSM stay in motor_ramp_ctrl.

Test Plan (sim params: TICK_DIV=4, STEP=16, DEAD_CYCLES=10, MAX_DUTY=1000):
1. Reset: rst high 3 cycles, then low → duty=0, dir=0, cmd_ready=1, busy=0, at_target=1.
2. Ramp up: accept cmd_duty=64, cmd_dir=0 at cycle T → duty 16/32/48/64 at T+4/8/12/16; IDLE and at_target=1 at T+17.
3. Clamp and ramp down:
   - From 64, cmd 70 → duty=70 at T+4.
   - Then cmd 0 → 54, 38, 22, 6, 0 at 4-cycle spacing.
4. Reversal: at duty=32, dir=0, cmd 32/dir=1 → 16, 0 (BRAKE); 10 DWELL cycles with duty=0; dir flips to 1; then 16, 32; cmd_ready=0 throughout BRAKE/DWELL.
5. Estop: assert estop at duty=48 mid-RAMP with cmd_valid high → duty=0 next cycle, state ESTOP, cmd not accepted. Deassert → IDLE next cycle, cmd_ready=1, dir unchanged.
6. Saturation/clip:
   - cmd 1023 → target 1000.
   - From 992, next tick gives 1000, not 1008.
   - Retarget to 500 mid-ramp → immediate downward stepping, no wrap.
